// File: rtl/reg_file_pkg.sv
// reg_file_pkg
// Shared sizing and types for the 2-read/1-write register file.
//   DATA_W    register width
//   NUM_REGS  register count (power of two)
//   ADDR_W    register address width
//   word_t, reg_addr_t  convenience types
//   ZERO_REG  index of the hardwired-zero register
package reg_file_pkg;

    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = $clog2(NUM_REGS);

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] reg_addr_t;

    localparam int ZERO_REG = 0;

endpackage

// File: rtl/reg_write_decoder.sv
// reg_write_decoder
// One-hot load decoder for the register file write port; the demux
// counterpart of the read-select muxes. Bit ZERO_REG is never set.
//   write_enable  in   write strobe
//   write_addr    in   destination register
//   load          out  one-hot (or all-zero) register load vector
module reg_write_decoder
    import reg_file_pkg::*;
#(
    parameter int NUM_REGS = reg_file_pkg::NUM_REGS,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                write_enable,
    input  logic [ADDR_W-1:0]   write_addr,
    output logic [NUM_REGS-1:0] load
);

    always_comb begin
        load = '0;
        if (write_enable && (int'(write_addr) != ZERO_REG))
            load[write_addr] = 1'b1;
    end

endmodule

// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w
// 32 x 32-bit register file, two combinational read ports, one
// synchronous write port, register 0 hardwired to zero.
//   clk, reset             clock; synchronous active-high reset
//   write_enable/addr/data write port, committed at the rising edge
//   read_addr_0/1          read port addresses
//   read_data_0/1          combinational read data
module reg_file_2r1w
    import reg_file_pkg::*;
#(
    parameter int DATA_W        = reg_file_pkg::DATA_W,
    parameter int NUM_REGS      = reg_file_pkg::NUM_REGS,
    parameter int ADDR_W        = $clog2(NUM_REGS),
    parameter int WRITE_THROUGH = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              write_enable,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] read_addr_0,
    input  logic [ADDR_W-1:0] read_addr_1,
    output logic [DATA_W-1:0] read_data_0,
    output logic [DATA_W-1:0] read_data_1
);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] wr_load;

    reg_write_decoder #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_dec (
        .write_enable (write_enable),
        .write_addr   (write_addr),
        .load         (wr_load)
    );

    // Entry 0 is only ever cleared; the decoder never loads it and the
    // read ports mask it, so it synthesizes away.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NUM_REGS; k++)
                regs[k] <= '0;
        end else begin
            for (int k = 1; k < NUM_REGS; k++)
                if (wr_load[k])
                    regs[k] <= write_data;
        end
    end

    // Write-through bypass deliberately ignores reset; zero-register mask
    // is applied last so it overrides the bypass.
    always_comb begin
        read_data_0 = regs[read_addr_0];
        if ((WRITE_THROUGH != 0) && write_enable && (write_addr == read_addr_0))
            read_data_0 = write_data;
        if (int'(read_addr_0) == ZERO_REG)
            read_data_0 = '0;
    end

    always_comb begin
        read_data_1 = regs[read_addr_1];
        if ((WRITE_THROUGH != 0) && write_enable && (write_addr == read_addr_1))
            read_data_1 = write_data;
        if (int'(read_addr_1) == ZERO_REG)
            read_data_1 = '0;
    end

endmodule

// File: tb/tb_reg_file_2r1w.sv
// tb_reg_file_2r1w
// Directed bench for reg_file_2r1w; a write-through and a non-write-through
// instance share the same stimulus.
module tb_reg_file_2r1w;

    logic        clk = 1'b0;
    logic        reset;
    logic        write_enable;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
    logic [4:0]  read_addr_0, read_addr_1;
    logic [31:0] rd0, rd1, rd0_n, rd1_n;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_file_2r1w #(.WRITE_THROUGH(1)) dut (
        .clk          (clk),
        .reset        (reset),
        .write_enable (write_enable),
        .write_addr   (write_addr),
        .write_data   (write_data),
        .read_addr_0  (read_addr_0),
        .read_addr_1  (read_addr_1),
        .read_data_0  (rd0),
        .read_data_1  (rd1)
    );

    reg_file_2r1w #(.WRITE_THROUGH(0)) dut_nwt (
        .clk          (clk),
        .reset        (reset),
        .write_enable (write_enable),
        .write_addr   (write_addr),
        .write_data   (write_data),
        .read_addr_0  (read_addr_0),
        .read_addr_1  (read_addr_1),
        .read_data_0  (rd0_n),
        .read_data_1  (rd1_n)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        write_enable = 1'b1;
        write_addr   = a;
        write_data   = d;
        tick();
        write_enable = 1'b0;
    endtask

    // Decoder load vector checked against an independent one-hot model
    // on every falling edge.
    logic        mon_en = 1'b0;
    logic [31:0] exp_load;
    always @(negedge clk) begin
        if (mon_en) begin
            exp_load = 32'd0;
            if (write_enable && write_addr != 5'd0)
                exp_load = 32'd1 << write_addr;
            chk("decoder_onehot", dut.wr_load, exp_load);
        end
    end

    initial begin
        reset = 1'b1; write_enable = 1'b0; write_addr = '0; write_data = '0;
        read_addr_0 = '0; read_addr_1 = '0;
        tick();
        reset = 1'b0;
        mon_en = 1'b1;
        read_addr_0 = 5'd5; read_addr_1 = 5'd17;
        #1;
        chk("reset_state_p0_x5", rd0, 32'h0);
        chk("reset_state_p1_x17", rd1, 32'h0);

        // Reset clears a written register and every address
        wr(5'd5, 32'hDEADBEEF);
        read_addr_0 = 5'd5;
        #1;
        chk("pre_reset_x5", rd0, 32'hDEADBEEF);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("post_reset_x5", rd0, 32'h0);
        for (int k = 0; k < 32; k++) begin
            read_addr_0 = 5'(k); read_addr_1 = 5'(31 - k);
            #1;
            chk("reset_all_p0", rd0, 32'h0);
            chk("reset_all_p1", rd1, 32'h0);
        end

        // Basic write/read
        wr(5'd7, 32'h12345678);
        wr(5'd31, 32'hCAFEF00D);
        read_addr_0 = 5'd7; read_addr_1 = 5'd31;
        #1;
        chk("basic_p0_x7", rd0, 32'h12345678);
        chk("basic_p1_x31", rd1, 32'hCAFEF00D);
        read_addr_1 = 5'd7;
        #1;
        chk("same_reg_p1_x7", rd1, 32'h12345678);

        // x0 stays zero during and after a write to it
        write_enable = 1'b1; write_addr = 5'd0; write_data = 32'hFFFFFFFF;
        read_addr_0 = 5'd0; read_addr_1 = 5'd0;
        #1;
        chk("x0_during_p0", rd0, 32'h0);
        chk("x0_during_p1", rd1, 32'h0);
        tick();
        write_enable = 1'b0;
        #1;
        chk("x0_after_p0", rd0, 32'h0);
        chk("x0_after_p1", rd1, 32'h0);
        chk("x0_after_nwt", rd0_n, 32'h0);

        // Write-through vs registered read
        wr(5'd3, 32'h1);
        write_enable = 1'b1; write_addr = 5'd3; write_data = 32'hAAAA5555;
        read_addr_0 = 5'd3; read_addr_1 = 5'd3;
        #1;
        chk("wt_p0", rd0, 32'hAAAA5555);
        chk("wt_p1", rd1, 32'hAAAA5555);
        chk("nwt_p0", rd0_n, 32'h00000001);
        chk("nwt_p1", rd1_n, 32'h00000001);
        tick();
        write_enable = 1'b0;
        #1;
        chk("wt_after_x3", rd0, 32'hAAAA5555);
        chk("nwt_after_x3", rd1_n, 32'hAAAA5555);

        // Reset/write collision: write dropped, bypass still visible
        reset = 1'b1; write_enable = 1'b1; write_addr = 5'd9; write_data = 32'h55;
        read_addr_0 = 5'd9; read_addr_1 = 5'd9;
        #1;
        chk("collide_bypass_wt", rd0, 32'h55);
        tick();
        reset = 1'b0; write_enable = 1'b0;
        #1;
        chk("collide_x9_wt", rd0, 32'h0);
        chk("collide_x9_nwt", rd1_n, 32'h0);
        read_addr_0 = 5'd3;
        #1;
        chk("collide_x3_cleared", rd0, 32'h0);

        // Back-to-back writes to one register
        wr(5'd12, 32'h111);
        write_enable = 1'b1; write_addr = 5'd12; write_data = 32'h222;
        read_addr_0 = 5'd12; read_addr_1 = 5'd12;
        #1;
        chk("b2b_first_nwt", rd0_n, 32'h111);
        tick();
        write_enable = 1'b0;
        #1;
        chk("b2b_last_wt", rd0, 32'h222);
        chk("b2b_last_nwt", rd1_n, 32'h222);

        // Exhaustive decode: xk = k+1, no aliasing
        for (int k = 1; k < 32; k++)
            wr(5'(k), 32'(k + 1));
        for (int k = 0; k < 32; k++) begin
            read_addr_0 = 5'(k); read_addr_1 = 5'(31 - k);
            #1;
            chk("exh_p0", rd0, (k == 0) ? 32'h0 : 32'(k + 1));
            chk("exh_p1", rd1, (k == 31) ? 32'h0 : 32'(32 - k));
        end

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        errors++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
